uart_loop_fifo: RTL and testbench
=================================

# uart_loop_fifo

Byte FIFO and transmit scheduler between the UART receiver and transmitter in the loopback path. Captures each byte completed by the receiver, buffers up to DEPTH bytes, and issues one single-cycle launch pulse per byte to the transmitter whenever it is idle. Bursts arriving faster than the transmitter drains are absorbed instead of being dropped or overwriting a frame in flight.

## Interface
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- AW, 4: address width; must equal log2(DEPTH).
- ACK_WAIT, 4: cycles to wait for tx_busy to rise after a launch before returning to idle (1..255).

- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid while rx_done is high.
- rx_done  in  1  receiver byte-complete strobe; rising edge = one byte.
- tx_busy  in  1  transmitter busy; high while a frame is shifting out.
- tx_en  out  1  one-cycle launch pulse to the transmitter.
- tx_data  out  8  byte for the transmitter; stable from the tx_en cycle until the next pop.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  AW+1  bytes stored.
- overflow  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.

## Operation
- Reset values:
  - tx_en=0, tx_data=8'h00, full=0, empty=1, count=0, overflow=0.
  - Pointers 0, state IDLE, rx_done history register 0.
- Push:
  - push = rx_done & ~rx_done_q, where rx_done_q is rx_done registered. One write per rising edge; a held-high rx_done writes once.
  - Write rx_data at wr_ptr, wr_ptr increments modulo DEPTH.
  - Push while full and no pop in the same cycle: byte discarded, pointers unchanged, overflow=1 for one cycle.
- Pop: only in state IDLE when !empty && !tx_busy.
  - mem[rd_ptr] is registered into tx_data, tx_en<=1, rd_ptr increments modulo DEPTH, state<=WAIT_HI.
- Simultaneous push and pop:
  - When full: both succeed, count unchanged, no overflow.
  - When empty: no pop that cycle (empty is registered); the byte pops on the next eligible cycle.
- count/full/empty are registered and updated on the same edge as the pointers: +1 on push only, -1 on pop only, unchanged on both.
- State machine:
  - IDLE: pop condition true -> WAIT_HI, loading the ack counter with ACK_WAIT.
  - WAIT_HI:
    - tx_busy=1 -> WAIT_LO.
    - Otherwise the counter decrements; on reaching 0 -> IDLE. This covers a transmitter with no busy output.
  - WAIT_LO: tx_busy=0 -> IDLE.
- tx_en is high only in the first WAIT_HI cycle, and is never high in two consecutive cycles.
- Reset asserted mid-operation: all state returns to reset values immediately. Buffered bytes are lost, and an in-flight tx_en is deasserted asynchronously.

## Timing
- rx_done first sampled high at edge k: byte written at edge k, empty falls after edge k.
- If IDLE and tx_busy=0: pop at edge k+1; tx_en high and tx_data valid from edge k+1 to edge k+2. Latency is 1 cycle from write to launch.
- Minimum spacing between tx_en pulses:
  - Transmitter that raises busy: 1 launch cycle + busy duration + 1 cycle (the IDLE re-check).
  - No-busy transmitter: ACK_WAIT+1 cycles.
- overflow is asserted in the cycle after the dropped push edge.
- Pointers use AW bits with natural wrap; count uses AW+1 bits so DEPTH is representable.

## Test plan
- Single byte 8'hA5, tx_busy tied 0, ACK_WAIT=4 -> tx_en pulses once, 2 edges after rx_done rises, with tx_data=8'hA5; count returns to 0; empty=1.
- Burst of 5 bytes 8'h01..8'h05 spaced 2 cycles apart; a model transmitter holds tx_busy high for 20 cycles starting 1 cycle after each tx_en -> 5 pulses in order 01..05, one per busy window, none while tx_busy=1.
- Hold tx_busy=1 and push 17 bytes with DEPTH=16 -> full=1 after the 16th push; overflow pulses exactly once, on the 17th; count=16. Release tx_busy -> bytes 1..16 emerge in order and the 17th never appears.
- With the FIFO full, push on the same edge as a pop -> count stays 16, overflow=0, the new byte is the last one out.
- rx_done held high for 10 cycles with rx_data=8'h3C -> exactly one write, count=1.
- Assert rst_n=0 while in WAIT_LO with count=3 -> tx_en=0, count=0, empty=1 immediately. After release with no pushes, no tx_en occurs.

Source files
------------

// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo
// Byte FIFO and transmit scheduler that sits between the UART receiver and
// the UART transmitter in the loopback path. Each rising edge of
// i_rx_done stores one byte. Whenever the transmitter is idle, one byte is
// launched with a single-cycle o_tx_en pulse. Bursts that arrive faster than
// the transmitter can drain them are buffered, up to DEPTH bytes.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_rx_data    received byte, valid while i_rx_done is high
//   i_rx_done    receiver byte-complete strobe (rising edge = one byte)
//   i_tx_busy    transmitter busy, high while a frame shifts out
//   o_tx_en      one-cycle launch pulse to the transmitter
//   o_tx_data    byte for the transmitter, held until the next pop
//   o_full       count == DEPTH
//   o_empty      count == 0
//   o_count      bytes currently stored
//   o_overflow   one-cycle pulse when a byte is dropped on a full FIFO
//
// state   | meaning
// IDLE    | waiting for a stored byte and an idle transmitter
// WAIT_HI | byte launched, waiting for tx_busy to rise (or ack timeout)
// WAIT_LO | transmitter busy, waiting for tx_busy to fall
module uart_loop_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned ACK_WAIT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_done,
    input  logic          i_tx_busy,
    output logic          o_tx_en,
    output logic [7:0]    o_tx_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count,
    output logic          o_overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [7:0]  ACK_INIT = 8'(ACK_WAIT);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic          r_rx_done_q;
    logic          r_full;
    logic          r_empty;
    logic          r_tx_en;
    logic          r_overflow;
    logic [7:0]    r_tx_data;
    logic [7:0]    r_ack_cnt;
    logic          w_push;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic          w_ack_load;
    logic          w_ack_dec;

    assign w_push = i_rx_done & ~r_rx_done_q;
    // A pop on the same edge frees the slot being written, so a full FIFO
    // still accepts the byte; only a push with no pop is dropped.
    assign w_wr   = w_push & (~r_full | w_pop);
    assign w_drop = w_push & r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_state_nxt = WAIT_HI;
            // Timeout path lets a transmitter without a busy output work.
            WAIT_HI: if (i_tx_busy)              w_state_nxt = WAIT_LO;
                     else if (r_ack_cnt <= 8'd1) w_state_nxt = IDLE;
            WAIT_LO: if (!i_tx_busy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_pop      = 1'b0;
        w_ack_load = 1'b0;
        w_ack_dec  = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop      = ~r_empty & ~i_tx_busy;
                w_ack_load = ~r_empty & ~i_tx_busy;
            end
            WAIT_HI: w_ack_dec = ~i_tx_busy;
            default: ;
        endcase
    end

    // Storage has no reset; the pointers define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_rx_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_done_q <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_tx_en     <= 1'b0;
            r_tx_data   <= 8'h00;
            r_overflow  <= 1'b0;
            r_ack_cnt   <= 8'h00;
        end else begin
            r_rx_done_q <= i_rx_done;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tx_data <= r_mem[r_rd_ptr];
            end
            r_tx_en    <= w_pop;
            r_overflow <= w_drop;
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == FULL_CNT);
            r_empty    <= (w_count_nxt == '0);
            if (w_ack_load)     r_ack_cnt <= ACK_INIT;
            else if (w_ack_dec) r_ack_cnt <= r_ack_cnt - 1'b1;
        end
    end

    assign o_tx_en    = r_tx_en;
    assign o_tx_data  = r_tx_data;
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Testbench for uart_loop_fifo (DEPTH=16, AW=4, ACK_WAIT=4).
// Launched bytes are checked against a queue of expected bytes; the fill
// and overflow sequence is a per-cycle vector table.
module tb_uart_loop_fifo;

    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int ACK_WAIT = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          tx_busy;
    logic          tx_en;
    logic [7:0]    tx_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;

    logic          tb_busy;
    logic          model_busy;
    logic          use_model;

    int            n_vec;
    int            n_err;
    int            n_launch;
    logic [7:0]    exp_q[$];

    typedef struct {
        logic        done;
        logic [7:0]  data;
        logic        accept;
        logic [AW:0] cnt;
        logic        emp;
        logic        ful;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    assign tx_busy = use_model ? model_busy : tb_busy;

    uart_loop_fifo #(.DEPTH(DEPTH), .AW(AW), .ACK_WAIT(ACK_WAIT)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_done  (rx_done),
        .i_tx_busy  (tx_busy),
        .o_tx_en    (tx_en),
        .o_tx_data  (tx_data),
        .o_full     (full),
        .o_empty    (empty),
        .o_count    (count),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_row(input logic d, input logic [7:0] dat, input logic acc,
                           input int c, input logic ovf);
        vec_t v;
        v.done   = d;
        v.data   = dat;
        v.accept = acc;
        v.cnt    = (AW+1)'(c);
        v.emp    = (c == 0);
        v.ful    = (c == DEPTH);
        v.ovf    = ovf;
        tbl.push_back(v);
    endtask

    // Launch monitor: each tx_en must match the oldest expected byte, must
    // follow an edge where tx_busy was low, and must not repeat back to back.
    logic prev_en = 1'b0;
    always begin
        logic b;
        @(posedge clk);
        b = tx_busy;
        #1;
        if (rst_n && tx_en) begin
            n_launch++;
            chk("tx_en_while_busy", {31'd0, b}, 32'd0);
            chk("tx_en_back_to_back", {31'd0, prev_en}, 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_launch: got tx_data %0h expected no launch", tx_data);
            end else begin
                chk("tx_data_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_en = tx_en;
    end

    // Model transmitter: busy for 20 cycles starting one cycle after a launch.
    always begin
        @(posedge clk);
        #1;
        if (use_model && tx_en) begin
            tick();
            model_busy = 1'b1;
            repeat (20) tick();
            model_busy = 1'b0;
        end
    end

    task automatic drain(input string nm, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        int base;
        n_vec = 0; n_err = 0; n_launch = 0;
        rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0;
        tb_busy = 1'b0; model_busy = 1'b0; use_model = 1'b0;

        // Fill/overflow table: tx_busy held high so nothing drains.
        for (int i = 0; i < 10; i++) add_row(1'b1, 8'h3C, (i == 0), 1, 1'b0);
        add_row(1'b0, 8'h3C, 1'b0, 1, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            add_row(1'b1, 8'(i), 1'b1, 1 + i, 1'b0);
            add_row(1'b0, 8'(i), 1'b0, 1 + i, 1'b0);
        end
        add_row(1'b1, 8'hEE, 1'b0, 16, 1'b1);
        add_row(1'b0, 8'hEE, 1'b0, 16, 1'b0);

        // Reset state
        repeat (3) tick();
        chk("rst_tx_en", {31'd0, tx_en}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single byte, no-busy transmitter: launch two edges after rx_done rises.
        rx_data = 8'hA5; rx_done = 1'b1; exp_q.push_back(8'hA5);
        tick();
        rx_done = 1'b0;
        chk("single_count_after_write", {27'd0, count}, 32'd1);
        chk("single_no_early_launch", {31'd0, tx_en}, 32'd0);
        tick();
        chk("single_tx_en", {31'd0, tx_en}, 32'd1);
        chk("single_tx_data", {24'd0, tx_data}, 32'hA5);
        chk("single_count_after_pop", {27'd0, count}, 32'd0);
        chk("single_empty", {31'd0, empty}, 32'd1);
        repeat (10) tick();
        chk("single_one_launch", n_launch, 1);

        // Burst of 5 against a transmitter that raises busy.
        use_model = 1'b1;
        base = n_launch;
        for (int i = 1; i <= 5; i++) begin
            rx_data = 8'(i); rx_done = 1'b1; exp_q.push_back(8'(i));
            tick();
            rx_done = 1'b0;
            tick();
        end
        drain("burst_drain", 400);
        repeat (30) tick();
        chk("burst_launches", n_launch - base, 5);
        use_model = 1'b0;
        tb_busy = 1'b1;
        tick();

        // Table: held rx_done writes once, fill to full, overflow on the extra.
        foreach (tbl[i]) begin
            rx_done = tbl[i].done;
            rx_data = tbl[i].data;
            if (tbl[i].accept) exp_q.push_back(tbl[i].data);
            tick();
            chk($sformatf("tbl%0d_count", i), {27'd0, count}, {27'd0, tbl[i].cnt});
            chk($sformatf("tbl%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].emp});
            chk($sformatf("tbl%0d_full", i), {31'd0, full}, {31'd0, tbl[i].ful});
            chk($sformatf("tbl%0d_overflow", i), {31'd0, overflow}, {31'd0, tbl[i].ovf});
        end

        // Full FIFO: push on the same edge as the first pop.
        tb_busy = 1'b0; rx_data = 8'h77; rx_done = 1'b1; exp_q.push_back(8'h77);
        tick();
        rx_done = 1'b0;
        chk("simul_tx_en", {31'd0, tx_en}, 32'd1);
        chk("simul_count", {27'd0, count}, 32'd16);
        chk("simul_full", {31'd0, full}, 32'd1);
        chk("simul_overflow", {31'd0, overflow}, 32'd0);

        // No-busy transmitter: launches spaced ACK_WAIT+1 cycles.
        c = 0;
        do begin
            tick();
            c++;
        end while (!tx_en && c < 20);
        chk("nobusy_gap", c, ACK_WAIT + 1);
        drain("full_drain", 400);
        repeat (8) tick();
        chk("drained_count", {27'd0, count}, 32'd0);
        chk("drained_empty", {31'd0, empty}, 32'd1);

        // Reset while in WAIT_LO with three bytes still stored.
        tb_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'hB0 + 8'(i); rx_done = 1'b1; exp_q.push_back(8'hB0 + 8'(i));
            tick();
            rx_done = 1'b0;
            tick();
        end
        tb_busy = 1'b0;
        tick();
        tb_busy = 1'b1;
        tick();
        chk("wlo_count_before_rst", {27'd0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx_en", {31'd0, tx_en}, 32'd0);
        chk("async_rst_count", {27'd0, count}, 32'd0);
        chk("async_rst_empty", {31'd0, empty}, 32'd1);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tb_busy = 1'b0;
        base = n_launch;
        repeat (30) tick();
        chk("post_rst_no_launch", n_launch - base, 0);
        chk("post_rst_count", {27'd0, count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
